// File: rtl/mpadder_pkg.sv
// mpadder_pkg: shared definitions for the multi-precision adder sequencer.
//   op_e        : operation codes sampled with start
//   state_e     : sequencer state encoding
//   IDLE_PHASE_DEF, NUM_SEG, LAST_SEG : phase constants for the 103-bit
//                 carry-propagate stage, which is split into six segments
//   op_to_state : maps a latched op code to the first working state
package mpadder_pkg;

  typedef enum logic [1:0] {
    OP_ACC     = 2'b00,
    OP_SHIFT   = 2'b01,
    OP_RESOLVE = 2'b10,
    OP_REDUCE  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACC    = 3'd1,
    ST_SHF    = 3'd2,
    ST_RES    = 3'd3,
    ST_SUB    = 3'd4,
    ST_COMMIT = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  // Bit 3 set means "no segment selected" and freezes the adder pipeline.
  localparam logic [3:0] IDLE_PHASE_DEF = 4'b1000;
  localparam int         NUM_SEG        = 6;
  localparam logic [2:0] LAST_SEG       = 3'(NUM_SEG - 1);

  function automatic state_e op_to_state(input op_e op_code);
    state_e st;
    unique case (op_code)
      OP_ACC:     st = ST_ACC;
      OP_SHIFT:   st = ST_SHF;
      OP_RESOLVE: st = ST_RES;
      default:    st = ST_SUB;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/mpadder_seq.sv
// mpadder_seq: control sequencer for a multi-precision carry-save adder.
// Ports:
//   clk          : clock, rising edge
//   resetn       : asynchronous active-low reset
//   start, op    : operation request and code (ACC/SHIFT/RESOLVE/REDUCE)
//   sub_finished : subtract-finished flag, looked at only in SUB at phase 5
//   busy, done   : operation in progress / one-cycle completion pulse
//   err          : REDUCE ran out of passes; valid with done, held until
//                  the next accepted start
//   phase        : segment select for the carry-propagate stage
//   enable_c     : carry-save register load strobe
//   shift        : carry-save register right-shift strobe
//   subtract     : subtract-mode select
//   dbg_state    : current sequencer state
//
// Handshake: start is accepted on a rising edge where the sequencer is idle
// and busy=0. busy rises in the cycle after acceptance and stays high until
// the DONE cycle (the one with done=1) has passed. start while busy=1 is
// dropped, never queued. The cycle right after acceptance is a latch cycle:
// the op code is registered there and the working state begins on the
// following edge.
//
// Every output is a flop. The output flops are loaded from the next-state
// decode, so they always describe the state the FSM is in during the same
// cycle, and sub_finished is therefore judged in the cycle where the outputs
// read phase=5, subtract=1.
module mpadder_seq
  import mpadder_pkg::*;
#(
  parameter int         MAX_PASS   = 4,
  parameter logic [3:0] IDLE_PHASE = IDLE_PHASE_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       sub_finished,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] phase,
  output logic       enable_c,
  output logic       shift,
  output logic       subtract,
  output state_e     dbg_state
);

  state_e     r_state;
  op_e        r_op;
  logic [2:0] r_cnt;
  logic [3:0] r_pass;
  logic       r_err;
  logic       r_busy;
  logic       r_done;
  logic [3:0] r_phase;
  logic       r_enable_c;
  logic       r_shift;
  logic       r_subtract;

  state_e     w_next_state;
  op_e        w_next_op;
  logic [2:0] w_next_cnt;
  logic [3:0] w_next_pass;
  logic       w_next_err;
  logic       w_accept;

  logic       w_busy_n;
  logic       w_done_n;
  logic [3:0] w_phase_n;
  logic       w_enable_c_n;
  logic       w_shift_n;
  logic       w_subtract_n;

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    w_next_op    = r_op;
    w_next_cnt   = r_cnt;
    w_next_pass  = r_pass;
    w_next_err   = r_err;
    w_accept     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (r_busy) begin
          // Latch cycle: the request was taken on the previous edge.
          w_next_state = op_to_state(r_op);
          w_next_cnt   = '0;
          w_next_pass  = 4'd1;
        end else if (start) begin
          w_accept   = 1'b1;
          w_next_op  = op_e'(op);
          w_next_err = 1'b0;
        end
      end
      ST_ACC:    w_next_state = ST_DONE;
      ST_SHF:    w_next_state = ST_DONE;
      ST_RES: begin
        if (r_cnt == LAST_SEG) begin
          w_next_cnt   = '0;
          w_next_state = ST_DONE;
        end else begin
          w_next_cnt = r_cnt + 3'd1;
        end
      end
      ST_SUB: begin
        if (r_cnt == LAST_SEG) begin
          w_next_cnt = '0;
          if (sub_finished) begin
            w_next_state = ST_COMMIT;
          end else if (r_pass < 4'(MAX_PASS)) begin
            w_next_pass = r_pass + 4'd1;
          end else begin
            w_next_err   = 1'b1;
            w_next_state = ST_DONE;
          end
        end else begin
          w_next_cnt = r_cnt + 3'd1;
        end
      end
      ST_COMMIT: w_next_state = ST_DONE;
      ST_DONE:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Output decode from the next state, registered below.
  always_comb begin
    w_busy_n     = (w_next_state != ST_IDLE) || w_accept;
    w_done_n     = (w_next_state == ST_DONE);
    w_enable_c_n = (w_next_state == ST_ACC);
    w_shift_n    = (w_next_state == ST_SHF);
    w_subtract_n = (w_next_state == ST_SUB) || (w_next_state == ST_COMMIT);
    w_phase_n    = IDLE_PHASE;
    if ((w_next_state == ST_RES) || (w_next_state == ST_SUB)) begin
      w_phase_n = {1'b0, w_next_cnt};
    end else if (w_next_state == ST_COMMIT) begin
      w_phase_n = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_ACC;
      r_cnt      <= '0;
      r_pass     <= '0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_phase    <= IDLE_PHASE;
      r_enable_c <= 1'b0;
      r_shift    <= 1'b0;
      r_subtract <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_op       <= w_next_op;
      r_cnt      <= w_next_cnt;
      r_pass     <= w_next_pass;
      r_err      <= w_next_err;
      r_busy     <= w_busy_n;
      r_done     <= w_done_n;
      r_phase    <= w_phase_n;
      r_enable_c <= w_enable_c_n;
      r_shift    <= w_shift_n;
      r_subtract <= w_subtract_n;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign phase     = r_phase;
  assign enable_c  = r_enable_c;
  assign shift     = r_shift;
  assign subtract  = r_subtract;
  assign dbg_state = r_state;

endmodule
